pipe_hazard_ctrl: RTL and testbench

- Central stall/flush/PC-select sequencer for the 5-stage MIPS pipeline.
- Drives write-enable and flush controls of the PC, IF_ID, ID_EX, EX_MEM and MEM_WB registers.
- Handles load-use hazards, taken beq (resolved in EX), j (resolved in ID), data-memory wait states with timeout, and external interrupt entry.
- Holds a small FSM and a saturating stall counter for performance monitoring.

---
 rtl/pipe_hazard_ctrl_pkg.sv | 49 ++++
 rtl/pipe_hazard_ctrl_if.sv | 46 ++++
 rtl/pipe_hazard_ctrl_load_use_detect.sv | 22 ++
 rtl/pipe_hazard_ctrl.sv | 127 ++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared encodings for the pipeline hazard sequencer: PC select codes,
// FSM states and the bundled control word driven each cycle.
package pipe_hazard_ctrl_pkg;

  localparam int REG_W  = 5;
  localparam int WAIT_W = 8;

  typedef enum logic [1:0] {
    PCSEL_SEQ = 2'b00,
    PCSEL_BR  = 2'b01,
    PCSEL_JMP = 2'b10,
    PCSEL_VEC = 2'b11
  } pcsel_e;

  typedef enum logic [1:0] {
    ST_RUN      = 2'b00,
    ST_MEM_WAIT = 2'b01,
    ST_EXC      = 2'b10
  } state_e;

  typedef struct packed {
    logic   pc_we;
    logic   if_id_we;
    logic   id_ex_we;
    logic   ex_mem_we;
    logic   mem_wb_we;
    logic   if_id_flush;
    logic   id_ex_flush;
    logic   ex_mem_flush;
    pcsel_e pc_sel;
    logic   epc_we;
    logic   irq_ack;
    logic   bus_err;
  } ctrl_t;

  // Free-running pipeline: every register advances, sequential PC, no flush.
  function automatic ctrl_t ctrl_advance();
    ctrl_t c;
    c           = '0;
    c.pc_we     = 1'b1;
    c.if_id_we  = 1'b1;
    c.id_ex_we  = 1'b1;
    c.ex_mem_we = 1'b1;
    c.mem_wb_we = 1'b1;
    c.pc_sel    = PCSEL_SEQ;
    return c;
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Bundle between the pipeline datapath (master) and the hazard sequencer (slave).
interface pipe_hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  import pipe_hazard_ctrl_pkg::*;

  logic [REG_W-1:0] id_rs;
  logic [REG_W-1:0] id_rt;
  logic             id_use_rs;
  logic             id_use_rt;
  logic             id_jump;
  logic             ex_memrd;
  logic [REG_W-1:0] ex_rt;
  logic             ex_branch_taken;
  logic             mem_busy;
  logic             irq;

  logic             pc_we;
  logic             if_id_we;
  logic             id_ex_we;
  logic             ex_mem_we;
  logic             mem_wb_we;
  logic             if_id_flush;
  logic             id_ex_flush;
  logic             ex_mem_flush;
  logic [1:0]       pc_sel;
  logic             epc_we;
  logic             irq_ack;
  logic             bus_err;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output id_rs, id_rt, id_use_rs, id_use_rt, id_jump, ex_memrd, ex_rt,
           ex_branch_taken, mem_busy, irq,
    input  pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we, if_id_flush,
           id_ex_flush, ex_mem_flush, pc_sel, epc_we, irq_ack, bus_err, stall_cnt
  );

  modport slave (
    input  id_rs, id_rt, id_use_rs, id_use_rt, id_jump, ex_memrd, ex_rt,
           ex_branch_taken, mem_busy, irq,
    output pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we, if_id_flush,
           id_ex_flush, ex_mem_flush, pc_sel, epc_we, irq_ack, bus_err, stall_cnt
  );

endinterface

// File: rtl/pipe_hazard_ctrl_load_use_detect.sv
// Combinational load-use compare between the load in EX and the sources of ID.
// Register $0 is hardwired to zero and never forms a dependency.
module load_use_detect
  import pipe_hazard_ctrl_pkg::*;
(
  input  logic             i_ex_memrd,
  input  logic [REG_W-1:0] i_ex_rt,
  input  logic [REG_W-1:0] i_id_rs,
  input  logic [REG_W-1:0] i_id_rt,
  input  logic             i_id_use_rs,
  input  logic             i_id_use_rt,
  output logic             o_hazard
);

  logic w_rs_hit;
  logic w_rt_hit;

  assign w_rs_hit = i_id_use_rs && (i_id_rs == i_ex_rt);
  assign w_rt_hit = i_id_use_rt && (i_id_rt == i_ex_rt);
  assign o_hazard = i_ex_memrd && (i_ex_rt != '0) && (w_rs_hit || w_rt_hit);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush/PC-select sequencer for the 5-stage pipeline. Controls are
// decoded combinationally from state and inputs; state and counters are registered.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int MAX_WAIT = 8,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  pipe_hazard_ctrl_if.slave hz
);

  state_e              r_state;
  logic [WAIT_W-1:0]   r_wait_cnt;
  logic [CNT_W-1:0]    r_stall_cnt;

  logic                w_hazard;
  logic                w_run_decode;
  ctrl_t               w_ctrl;
  state_e              w_state_next;
  logic [WAIT_W-1:0]   w_wait_next;

  load_use_detect u_load_use_detect (
    .i_ex_memrd  (hz.ex_memrd),
    .i_ex_rt     (hz.ex_rt),
    .i_id_rs     (hz.id_rs),
    .i_id_rt     (hz.id_rt),
    .i_id_use_rs (hz.id_use_rs),
    .i_id_use_rt (hz.id_use_rt),
    .o_hazard    (w_hazard)
  );

  // A wait that ends this cycle falls straight through to the RUN decode.
  assign w_run_decode = (r_state == ST_RUN)
                     || ((r_state == ST_MEM_WAIT) && !hz.mem_busy)
                     || ((r_state != ST_MEM_WAIT) && (r_state != ST_EXC));

  always_comb begin
    w_ctrl       = '0;
    w_state_next = r_state;
    w_wait_next  = r_wait_cnt;

    if (!reset) begin
      w_ctrl.if_id_flush  = 1'b1;
      w_ctrl.id_ex_flush  = 1'b1;
      w_ctrl.ex_mem_flush = 1'b1;
      w_state_next        = ST_RUN;
      w_wait_next         = '0;
    end else if (r_state == ST_EXC) begin
      // Vector to the handler; the faulting load must not reach writeback.
      w_ctrl              = ctrl_advance();
      w_ctrl.mem_wb_we    = 1'b0;
      w_ctrl.if_id_flush  = 1'b1;
      w_ctrl.id_ex_flush  = 1'b1;
      w_ctrl.ex_mem_flush = 1'b1;
      w_ctrl.pc_sel       = PCSEL_VEC;
      w_ctrl.epc_we       = 1'b1;
      w_state_next        = ST_RUN;
    end else if (!w_run_decode) begin
      if (r_wait_cnt == WAIT_W'(MAX_WAIT)) begin
        w_ctrl.bus_err = 1'b1;
        w_state_next   = ST_EXC;
      end else begin
        w_wait_next = r_wait_cnt + 1'b1;
      end
    end else begin
      w_state_next = ST_RUN;
      if (hz.mem_busy) begin
        w_state_next = ST_MEM_WAIT;
        w_wait_next  = WAIT_W'(1);
      end else if (hz.ex_branch_taken) begin
        w_ctrl             = ctrl_advance();
        w_ctrl.if_id_flush = 1'b1;
        w_ctrl.id_ex_flush = 1'b1;
        w_ctrl.pc_sel      = PCSEL_BR;
      end else if (w_hazard) begin
        w_ctrl             = ctrl_advance();
        w_ctrl.pc_we       = 1'b0;
        w_ctrl.if_id_we    = 1'b0;
        w_ctrl.id_ex_flush = 1'b1;
      end else if (hz.irq) begin
        w_ctrl             = ctrl_advance();
        w_ctrl.if_id_flush = 1'b1;
        w_ctrl.id_ex_flush = 1'b1;
        w_ctrl.pc_sel      = PCSEL_VEC;
        w_ctrl.epc_we      = 1'b1;
        w_ctrl.irq_ack     = 1'b1;
      end else if (hz.id_jump) begin
        w_ctrl             = ctrl_advance();
        w_ctrl.if_id_flush = 1'b1;
        w_ctrl.pc_sel      = PCSEL_JMP;
      end else begin
        w_ctrl = ctrl_advance();
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_RUN;
      r_wait_cnt  <= '0;
      r_stall_cnt <= '0;
    end else begin
      r_state    <= w_state_next;
      r_wait_cnt <= w_wait_next;
      if (!w_ctrl.pc_we && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + 1'b1;
      end
    end
  end

  assign hz.pc_we        = w_ctrl.pc_we;
  assign hz.if_id_we     = w_ctrl.if_id_we;
  assign hz.id_ex_we     = w_ctrl.id_ex_we;
  assign hz.ex_mem_we    = w_ctrl.ex_mem_we;
  assign hz.mem_wb_we    = w_ctrl.mem_wb_we;
  assign hz.if_id_flush  = w_ctrl.if_id_flush;
  assign hz.id_ex_flush  = w_ctrl.id_ex_flush;
  assign hz.ex_mem_flush = w_ctrl.ex_mem_flush;
  assign hz.pc_sel       = w_ctrl.pc_sel;
  assign hz.epc_we       = w_ctrl.epc_we;
  assign hz.irq_ack      = w_ctrl.irq_ack;
  assign hz.bus_err      = w_ctrl.bus_err;
  assign hz.stall_cnt    = r_stall_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: directed scenarios plus random traffic,
// expectations from a cycle-level behavioural model of the sequencing rules.
module tb_pipe_hazard_ctrl;

  localparam int MAX_WAIT = 8;
  localparam int CNT_W    = 16;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  pipe_hazard_ctrl_if #(.CNT_W(CNT_W)) hz();

  pipe_hazard_ctrl #(.MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .hz    (hz)
  );

  typedef struct packed {
    logic       rst_n;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       use_rs;
    logic       use_rt;
    logic       jump;
    logic       memrd;
    logic [4:0] ex_rt;
    logic       br;
    logic       busy;
    logic       irq;
  } stim_t;

  typedef struct packed {
    logic        pc_we;
    logic        if_id_we;
    logic        id_ex_we;
    logic        ex_mem_we;
    logic        mem_wb_we;
    logic        if_id_flush;
    logic        id_ex_flush;
    logic        ex_mem_flush;
    logic [1:0]  pc_sel;
    logic        epc_we;
    logic        irq_ack;
    logic        bus_err;
    logic [15:0] stall_cnt;
  } exp_t;

  typedef struct {
    exp_t  e;
    string tag;
  } sb_t;

  sb_t   sb_q[$];
  int    n_cmp = 0;
  int    n_bad = 0;

  // Reference model state: cycles spent waiting, pending exception, stall tally.
  int    m_waited = 0;
  bit    m_exc    = 1'b0;
  int    m_stalls = 0;

  int    busy_left = 0;
  bit    irq_level = 1'b0;

  task automatic predict(input stim_t s, output exp_t e);
    bit lu;
    e = '0;
    if (!s.rst_n) begin
      e.if_id_flush  = 1'b1;
      e.id_ex_flush  = 1'b1;
      e.ex_mem_flush = 1'b1;
      m_waited = 0;
      m_exc    = 1'b0;
      m_stalls = 0;
      return;
    end
    e.stall_cnt = 16'(m_stalls);
    if (m_exc) begin
      e.pc_we = 1; e.if_id_we = 1; e.id_ex_we = 1; e.ex_mem_we = 1; e.mem_wb_we = 0;
      e.if_id_flush = 1; e.id_ex_flush = 1; e.ex_mem_flush = 1;
      e.pc_sel = 2'b11; e.epc_we = 1;
      m_exc = 1'b0;
    end else if (m_waited > 0 && s.busy) begin
      if (m_waited == MAX_WAIT) begin
        e.bus_err = 1'b1;
        m_waited  = 0;
        m_exc     = 1'b1;
      end else begin
        m_waited++;
      end
    end else begin
      m_waited = 0;
      lu = s.memrd && (s.ex_rt != 0) &&
           ((s.use_rs && s.id_rs == s.ex_rt) || (s.use_rt && s.id_rt == s.ex_rt));
      if (s.busy) begin
        m_waited = 1;
      end else begin
        e.pc_we = 1; e.if_id_we = 1; e.id_ex_we = 1; e.ex_mem_we = 1; e.mem_wb_we = 1;
        if (s.br) begin
          e.if_id_flush = 1; e.id_ex_flush = 1; e.pc_sel = 2'b01;
        end else if (lu) begin
          e.pc_we = 0; e.if_id_we = 0; e.id_ex_flush = 1;
        end else if (s.irq) begin
          e.if_id_flush = 1; e.id_ex_flush = 1; e.pc_sel = 2'b11;
          e.epc_we = 1; e.irq_ack = 1;
        end else if (s.jump) begin
          e.if_id_flush = 1; e.pc_sel = 2'b10;
        end
      end
    end
    if (!e.pc_we && m_stalls < 65535) m_stalls++;
  endtask

  task automatic step(input stim_t s, input string tag, output exp_t e);
    sb_t it;
    @(negedge clk);
    reset              = s.rst_n;
    hz.id_rs           = s.id_rs;
    hz.id_rt           = s.id_rt;
    hz.id_use_rs       = s.use_rs;
    hz.id_use_rt       = s.use_rt;
    hz.id_jump         = s.jump;
    hz.ex_memrd        = s.memrd;
    hz.ex_rt           = s.ex_rt;
    hz.ex_branch_taken = s.br;
    hz.mem_busy        = s.busy;
    hz.irq             = s.irq;
    predict(s, e);
    it.e   = e;
    it.tag = tag;
    sb_q.push_back(it);
  endtask

  // Monitor: every cycle the DUT presents a control word; check it off the queue.
  initial begin : monitor
    sb_t  it;
    exp_t a;
    forever begin
      @(negedge clk);
      #2;
      if (sb_q.size() > 0) begin
        it = sb_q.pop_front();
        a  = {hz.pc_we, hz.if_id_we, hz.id_ex_we, hz.ex_mem_we, hz.mem_wb_we,
              hz.if_id_flush, hz.id_ex_flush, hz.ex_mem_flush, hz.pc_sel,
              hz.epc_we, hz.irq_ack, hz.bus_err, hz.stall_cnt};
        n_cmp++;
        if (a !== it.e) begin
          n_bad++;
          $display("FAIL %s: got %h required %h (we5 fl3 sel2 epc ack berr cnt16)",
                   it.tag, a, it.e);
        end
      end
    end
  end

  initial begin : stimulus
    stim_t idle;
    stim_t s;
    exp_t  e;

    idle       = '0;
    idle.rst_n = 1'b1;
    reset      = 1'b0;
    hz.id_rs = '0; hz.id_rt = '0; hz.id_use_rs = 0; hz.id_use_rt = 0; hz.id_jump = 0;
    hz.ex_memrd = 0; hz.ex_rt = '0; hz.ex_branch_taken = 0; hz.mem_busy = 0; hz.irq = 0;

    s = idle; s.rst_n = 1'b0;
    step(s, "reset", e);
    step(s, "reset", e);
    step(idle, "idle", e);

    s = idle; s.memrd = 1; s.ex_rt = 5'd8; s.id_rs = 5'd8; s.use_rs = 1;
    step(s, "load_use", e);
    s = idle; s.id_rs = 5'd8; s.use_rs = 1;
    step(s, "load_use_after", e);
    s = idle; s.memrd = 1; s.ex_rt = 5'd0; s.id_rs = 5'd0; s.use_rs = 1;
    step(s, "load_use_r0", e);
    s = idle; s.memrd = 1; s.ex_rt = 5'd9; s.id_rt = 5'd9; s.use_rt = 1;
    step(s, "load_use_rt", e);

    s = idle; s.br = 1; s.irq = 1;
    step(s, "br_irq", e);
    s = idle; s.irq = 1;
    step(s, "irq_take", e);
    step(idle, "after_irq", e);
    s = idle; s.jump = 1;
    step(s, "jump", e);

    s = idle; s.busy = 1;
    repeat (3) step(s, "busy3", e);
    step(idle, "busy3_resume", e);

    repeat (MAX_WAIT + 1) step(s, "busy_timeout", e);
    step(s, "exc", e);
    step(idle, "post_exc", e);

    for (int i = 0; i < 3000; i++) begin
      s = idle;
      if (busy_left == 0 && $urandom_range(0, 9) == 0)
        busy_left = $urandom_range(1, MAX_WAIT + 3);
      s.busy = (busy_left > 0);
      if (busy_left > 0) busy_left--;
      if (!irq_level && $urandom_range(0, 7) == 0) irq_level = 1'b1;
      s.irq    = irq_level;
      s.id_rs  = 5'($urandom_range(0, 3));
      s.id_rt  = 5'($urandom_range(0, 3));
      s.ex_rt  = 5'($urandom_range(0, 3));
      s.use_rs = 1'($urandom_range(0, 1));
      s.use_rt = 1'($urandom_range(0, 1));
      s.memrd  = ($urandom_range(0, 2) == 0);
      s.br     = ($urandom_range(0, 7) == 0);
      s.jump   = ($urandom_range(0, 5) == 0);
      step(s, "random", e);
      if (e.irq_ack) irq_level = 1'b0;
    end

    s = idle; s.busy = 1;
    repeat (3) step(s, "busy_pre_rst", e);
    s.rst_n = 1'b0;
    step(s, "rst_mid_wait", e);
    step(s, "rst_hold", e);
    step(idle, "post_rst", e);
    step(idle, "post_rst2", e);

    repeat (2) @(negedge clk);
    #5;
    if (sb_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d entries left, required 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
